multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style control state machine for the multicycle MIPS datapath. It sits directly upstream of the ALU. It decodes the instruction-register opcode and funct fields and drives the ALU `select` code, the operand-mux selects and every datapath write enable. It consumes the ALU `zero` flag to resolve branches.

## Interface
**Parameters**
- `STATE_W`, default 4: width of the exported state code.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous reset, active-low.
- `opcode`, in, 6: IR[31:26].
- `funct`, in, 6: IR[5:0].
- `zero`, in, 1: ALU zero flag, sampled combinationally in BRANCH.
- `mem_ready`, in, 1: memory completes the current access this cycle.
- `mem_read`, out, 1: memory read request.
- `mem_write`, out, 1: memory write request.
- `iord`, out, 1: address mux (0 = PC, 1 = ALUOut).
- `ir_write`, out, 1: load the IR.
- `reg_dst`, out, 1: write-register mux (0 = rt, 1 = rd).
- `mem_to_reg`, out, 1: write-data mux (0 = ALUOut, 1 = MDR).
- `reg_write`, out, 1: register-file write enable.
- `alu_src_a`, out, 1: ALU operand A (0 = PC, 1 = A reg).
- `alu_src_b`, out, 2: ALU operand B (00 = B reg, 01 = const 4, 10 = ext imm, 11 = ext imm << 2).
- `ext_zero`, out, 1: immediate extension (0 = sign, 1 = zero).
- `alu_select`, out, 3: ALU op (000 add, 001 and, 010 or, 011 xor, 100 not, 101 shl1, 110 shr1).
- `pc_src`, out, 2: PC mux (00 = ALU y, 01 = ALUOut, 10 = jump target).
- `pc_en`, out, 1: PC load, equal to `pc_write | (pc_write_cond & zero)`.
- `illegal`, out, 1: sticky, set on an undecodable instruction.
- `state`, out, `STATE_W`: current state code, for debug.

## Operation
- **Supported R-type instructions** (opcode 000000), funct to `alu_select`:
  - 100000 add → 000
  - 100100 and → 001
  - 100101 or → 010
  - 100110 xor → 011
  - 100111 not → 100
  - 000000 shl1 → 101
  - 000010 shr1 → 110
- **Supported I/J-type instructions:**
  - lw 100011, sw 101011, addi 001000 (sign-extended immediate)
  - andi 001100, ori 001101, xori 001110 (zero-extended immediate)
  - beq 000100, j 000010
- **State codes:**
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR
  - 6 EXEC, 7 ALUWB, 8 BRANCH, 9 IEXEC, 10 IWB, 11 JUMP
- **Per-state outputs.** Every output not listed is 0.
  - FETCH: `mem_read`=1, `iord`=0, src_a=0, src_b=01, select=000, pc_src=00. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH while `mem_ready`=0, otherwise goes to DECODE.
  - DECODE: src_a=0, src_b=11, select=000 (the branch target is latched into ALUOut). Next state by opcode:
    - lw/sw → MEMADR
    - R-type with a legal funct → EXEC
    - addi/andi/ori/xori → IEXEC
    - beq → BRANCH
    - j → JUMP
    - anything else → FETCH, and set `illegal`
  - MEMADR: src_a=1, src_b=10, select=000, `ext_zero`=0. Goes to MEMRD (lw) or MEMWR (sw).
  - MEMRD: `mem_read`=1, `iord`=1. Waits on `mem_ready`, then goes to MEMWB.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
  - MEMWR: `mem_write`=1, `iord`=1. Waits on `mem_ready`, then goes to FETCH.
  - EXEC: src_a=1, src_b=00, select from funct. Goes to ALUWB.
  - ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
  - IEXEC: src_a=1, src_b=10, select 000/001/010/011 for addi/andi/ori/xori. `ext_zero`=1 except for addi. Goes to IWB.
  - IWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
  - BRANCH: src_a=1, src_b=00, select=011 (xor, so `zero`=1 iff rs==rt). `pc_write_cond`=1, pc_src=01. Goes to FETCH.
  - JUMP: pc_src=10, `pc_write`=1. Goes to FETCH.
- **Decode latching.** Opcode and funct are latched into internal registers on the FETCH→DECODE transition. Decisions in later states use these latched copies, never the live inputs.

## Timing
- **Reset.** With `rst_n`=0 at a rising edge, the state register loads FETCH, `illegal` clears, and the latched opcode/funct clear. While `rst_n`=0, all write and request enables are forced to 0 combinationally: `mem_read`, `mem_write`, `ir_write`, `reg_write`, `pc_en`. Mux selects stay at their FETCH values.
- **Reset mid-instruction.** Aborts the instruction. No partial `reg_write` or `mem_write` is issued after the reset edge.
- **Latency with `mem_ready` held at 1:** R-type 4 cycles, addi/andi/ori/xori 4, lw 5, sw 4, beq 3, j 3. Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- **Memory handshake.** `mem_read`/`mem_write` stay asserted continuously until the cycle in which `mem_ready`=1. The access completes in that cycle, and the state advances on the following edge.
- **Illegal instruction.** Costs 2 cycles (FETCH, DECODE) and performs no writes. `illegal` stays 1 until reset.
- **Branch resolution.** `pc_en` in BRANCH follows `zero` combinationally in the same cycle. `zero` must be settled before the edge.

## Test plan
- **Reset.** Hold `rst_n`=0 for 2 cycles with `mem_ready`=1. Required: state=0, `pc_en`=0, `ir_write`=0, `illegal`=0. After release, `pc_en`=1 in the first cycle.
- **R-type xor.** opcode 000000, funct 100110, `mem_ready`=1. Required: states 0,1,6,7,0; `alu_select`=011 in EXEC; `reg_write`=1 and `reg_dst`=1 only in ALUWB.
- **lw with stall.** opcode 100011, `mem_ready`=0 for 3 cycles in MEMRD. Required: MEMRD held 4 cycles with `mem_read`=1 and `iord`=1, then MEMWB with `mem_to_reg`=1; 8 cycles total.
- **beq.** opcode 000100, `zero`=1 in BRANCH. Required: `pc_en`=1, `pc_src`=01, `alu_select`=011. Repeat with `zero`=0: `pc_en`=0.
- **andi.** opcode 001100. Required: IEXEC has `ext_zero`=1, select=001, src_b=10; IWB writes rt.
- **Illegal, then reset mid-instruction.** opcode 111111. Required: return to FETCH after DECODE, `illegal`=1, no writes. Then start sw and assert `rst_n`=0 in MEMWR. Required: `mem_write`=0 immediately, state=FETCH after the edge, `illegal`=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: decodes the latched IR fields,
// sequences memory/ALU/writeback steps and drives every datapath select and enable.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_zero,
  output logic [2:0]         alu_select,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic       illegal_q, illegal_d;

  // Returns {legal, alu_select} for an R-type funct field.
  function automatic logic [3:0] rtype_decode(input logic [5:0] f);
    case (f)
      6'b100000: rtype_decode = {1'b1, 3'b000};
      6'b100100: rtype_decode = {1'b1, 3'b001};
      6'b100101: rtype_decode = {1'b1, 3'b010};
      6'b100110: rtype_decode = {1'b1, 3'b011};
      6'b100111: rtype_decode = {1'b1, 3'b100};
      6'b000000: rtype_decode = {1'b1, 3'b101};
      6'b000010: rtype_decode = {1'b1, 3'b110};
      default:   rtype_decode = {1'b0, 3'b000};
    endcase
  endfunction

  function automatic logic [2:0] imm_select(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_select = 3'b001;
      OP_ORI:  imm_select = 3'b010;
      OP_XORI: imm_select = 3'b011;
      default: imm_select = 3'b000;
    endcase
  endfunction

  logic [3:0] rdec;
  assign rdec = rtype_decode(funct_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
          op_d    = opcode;
          funct_d = funct;
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IEXEC;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_RTYPE: begin
            if (rdec[3]) begin
              state_d = S_EXEC;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // State boundary: decode copies and the sticky flag share the state register's reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
    end
  end

  logic pc_write, pc_write_cond;
  state_t out_state;

  // In reset the selects decode as FETCH; enables are cleared afterwards.
  assign out_state = rst_n ? state_q : S_FETCH;

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_select    = 3'b000;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    case (out_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_select = rdec[2:0];
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_select = imm_select(op_q);
        ext_zero   = (op_q != OP_ADDI);
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_select    = 3'b011;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    pc_en = pc_write | (pc_write_cond & zero);
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Scenario bench for multicycle_control: each cycle's expected output vector is queued
// from a per-state reference table when stimulus is applied and compared at the negedge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, pc_en, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_select;
  logic [3:0] state;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_select(alu_select), .pc_src(pc_src), .pc_en(pc_en),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_select;
    logic [1:0] pc_src;
    logic       pc_en, illegal;
  } vec_t;

  vec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  vec_t got, e;

  // Reference per-state output table; in reset, FETCH selects with all enables low.
  function automatic vec_t row(input int st, input bit mr, input bit z, input bit rstn,
                               input bit ill, input logic [2:0] sel, input bit ez);
    vec_t v;
    v = '0;
    v.st = st[3:0];
    v.illegal = ill;
    if (!rstn) begin
      v.alu_src_b = 2'b01;
      return v;
    end
    case (st)
      0:  begin v.mem_read = 1; v.alu_src_b = 2'b01; v.ir_write = mr; v.pc_en = mr; end
      1:  v.alu_src_b = 2'b11;
      2:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      3:  begin v.mem_read = 1; v.iord = 1; end
      4:  begin v.reg_write = 1; v.mem_to_reg = 1; end
      5:  begin v.mem_write = 1; v.iord = 1; end
      6:  begin v.alu_src_a = 1; v.alu_select = sel; end
      7:  begin v.reg_write = 1; v.reg_dst = 1; end
      8:  begin v.alu_src_a = 1; v.alu_select = 3'b011; v.pc_src = 2'b01; v.pc_en = z; end
      9:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_select = sel; v.ext_zero = ez; end
      10: v.reg_write = 1;
      11: begin v.pc_src = 2'b10; v.pc_en = 1; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic vec_t sample();
    return {state, mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, ext_zero, alu_select, pc_src, pc_en, illegal};
  endfunction

  task automatic drive(input bit rstn, input bit mr, input bit z, input vec_t exp_v);
    rst_n = rstn;
    mem_ready = mr;
    zero = z;
    sb.push_back(exp_v);
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int sts[6] = '{0, 0, 0, 1, 6, 7};
    bit rs[6]  = '{0, 0, 1, 1, 1, 1};
    opcode = 6'b000000;
    funct  = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      drive(rs[i], 1'b1, 1'b0, row(sts[i], 1'b1, 1'b0, rs[i], 1'b0, 3'b101, 1'b0));
      got = sample();
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset/shl1 cyc%0d got=%h exp=%h", i, got, e);
      end
      adv();
    end
  endtask

  task automatic test_rtype_xor();
    int sts[4] = '{0, 1, 6, 7};
    opcode = 6'b000000;
    funct  = 6'b100110;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        opcode = 6'b111111;
        funct  = 6'b000000;
      end
      drive(1'b1, 1'b1, 1'b0, row(sts[i], 1'b1, 1'b0, 1'b1, 1'b0, 3'b011, 1'b0));
      got = sample();
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL xor cyc%0d got=%h exp=%h", i, got, e);
      end
      adv();
    end
  endtask

  task automatic test_lw_stall();
    int sts[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    bit mrs[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    opcode = 6'b100011;
    funct  = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mrs[i], 1'b0, row(sts[i], mrs[i], 1'b0, 1'b1, 1'b0, 3'b000, 1'b0));
      got = sample();
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL lw_stall cyc%0d got=%h exp=%h", i, got, e);
      end
      adv();
    end
  endtask

  task automatic test_beq();
    int sts[6] = '{0, 1, 8, 0, 1, 8};
    bit zs[6]  = '{0, 1, 1, 1, 0, 0};
    opcode = 6'b000100;
    funct  = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, zs[i], row(sts[i], 1'b1, zs[i], 1'b1, 1'b0, 3'b000, 1'b0));
      got = sample();
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL beq cyc%0d zero=%0d got=%h exp=%h", i, zs[i], got, e);
      end
      adv();
    end
  endtask

  task automatic test_imm_and_jump();
    logic [5:0] ops[3]  = '{6'b001100, 6'b001000, 6'b000010};
    logic [2:0] sels[3] = '{3'b001, 3'b000, 3'b000};
    bit         ezs[3]  = '{1, 0, 0};
    int         sts[4];
    int         n;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      funct  = 6'b101010;
      if (k == 2) begin
        sts = '{0, 1, 11, 0};
        n = 3;
      end else begin
        sts = '{0, 1, 9, 10};
        n = 4;
      end
      for (int i = 0; i < n; i++) begin
        drive(1'b1, 1'b1, 1'b0, row(sts[i], 1'b1, 1'b0, 1'b1, 1'b0, sels[k], ezs[k]));
        got = sample();
        e = sb.pop_front();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL imm_j op=%b cyc%0d got=%h exp=%h", ops[k], i, got, e);
        end
        adv();
      end
    end
  endtask

  task automatic test_illegal_then_reset();
    int sts[8] = '{0, 1, 0, 1, 2, 5, 5, 0};
    bit ill[8] = '{0, 0, 1, 1, 1, 1, 1, 0};
    bit rs[8]  = '{1, 1, 1, 1, 1, 1, 0, 1};
    bit mrs[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    opcode = 6'b111111;
    funct  = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) opcode = 6'b101011;
      drive(rs[i], mrs[i], 1'b0, row(sts[i], mrs[i], 1'b0, rs[i], ill[i], 3'b000, 1'b0));
      got = sample();
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL illegal/sw_reset cyc%0d got=%h exp=%h", i, got, e);
      end
      adv();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b0;
    opcode = 6'd0;
    funct = 6'd0;
    adv();
    test_reset();
    test_rtype_xor();
    test_lw_stall();
    test_beq();
    test_imm_and_jump();
    test_illegal_then_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
